// File: rtl/ks_sum_inc_pipe_if.sv
// rtl/ks_sum_inc_pipe_if.sv - operand and result handshake bundle for ks_sum_inc_pipe
interface ks_sum_inc_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum0;
    logic [WIDTH-1:0] out_sum1;
    logic             out_cout0;
    logic             out_cout1;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_sum0, out_sum1, out_cout0, out_cout1, out_tag
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_sum0, out_sum1, out_cout0, out_cout1, out_tag
    );
endinterface

// File: rtl/ks_sum_inc_pipe.sv
// rtl/ks_sum_inc_pipe.sv - pipelined Kogge-Stone compound adder producing A+B' and A+B'+1
module ks_sum_inc_pipe #(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    ks_sum_inc_pipe_if.slave io
);
    // L prefix levels split into NB register banks; latency is 1 + NB.
    localparam int L  = $clog2(WIDTH);
    localparam int NB = (L + REG_EVERY - 1) / REG_EVERY;

    logic             advance;
    logic [WIDTH-1:0] b_eff;

    logic [WIDTH-1:0] g_q   [NB];
    logic [WIDTH-1:0] p_q   [NB];
    logic [WIDTH-1:0] r_q   [NB];
    logic [TAG_W-1:0] tag_q [NB];
    logic [NB-1:0]    v_q;

    logic [WIDTH-1:0] bank_g [NB];
    logic [WIDTH-1:0] bank_p [NB];

    logic [WIDTH-1:0] sum0_q, sum0_d;
    logic [WIDTH-1:0] sum1_q, sum1_d;
    logic             cout0_q, cout0_d;
    logic             cout1_q, cout1_d;
    logic [TAG_W-1:0] tag_o_q;
    logic             valid_o_q;

    assign advance     = !valid_o_q || io.out_ready;
    assign io.in_ready = advance;
    assign b_eff       = io.in_sub ? ~io.in_b : io.in_b;

    // Each bank starts from its stage register and runs up to REG_EVERY levels;
    // spans past bit 0 shift in zeros so low positions pass through untouched.
    always_comb begin : prefix_net
        logic [WIDTH-1:0] cur_g;
        logic [WIDTH-1:0] cur_p;
        cur_g = '0;
        cur_p = '0;
        for (int b = 0; b < NB; b++) begin
            bank_g[b] = '0;
            bank_p[b] = '0;
        end
        for (int k = 0; k < L; k++) begin
            if (k % REG_EVERY == 0) begin
                cur_g = g_q[k / REG_EVERY];
                cur_p = p_q[k / REG_EVERY];
            end
            cur_g = cur_g | (cur_p & (cur_g << (1 << k)));
            cur_p = cur_p & ((cur_p << (1 << k)) | ~({WIDTH{1'b1}} << (1 << k)));
            if (((k + 1) % REG_EVERY == 0) || (k == L - 1)) begin
                bank_g[k / REG_EVERY] = cur_g;
                bank_p[k / REG_EVERY] = cur_p;
            end
        end
    end

    // The +1 result reuses the same prefix: a carry-in of 1 turns every
    // all-propagate group into a carry, so no second adder is needed.
    always_comb begin : final_sums
        logic [WIDTH-1:0] gf;
        logic [WIDTH-1:0] pf;
        logic [WIDTH-1:0] c0;
        logic [WIDTH-1:0] c1;
        gf      = bank_g[NB-1];
        pf      = bank_p[NB-1];
        c0      = {gf[WIDTH-2:0], 1'b0};
        c1      = {gf[WIDTH-2:0] | pf[WIDTH-2:0], 1'b1};
        sum0_d  = r_q[NB-1] ^ c0;
        sum1_d  = r_q[NB-1] ^ c1;
        cout0_d = gf[WIDTH-1];
        cout1_d = gf[WIDTH-1] | pf[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NB; s++) begin
                g_q[s]   <= '0;
                p_q[s]   <= '0;
                r_q[s]   <= '0;
                tag_q[s] <= '0;
            end
            v_q       <= '0;
            sum0_q    <= '0;
            sum1_q    <= '0;
            cout0_q   <= 1'b0;
            cout1_q   <= 1'b0;
            tag_o_q   <= '0;
            valid_o_q <= 1'b0;
        end else if (advance) begin
            v_q[0]   <= io.in_valid;
            g_q[0]   <= io.in_a & b_eff;
            p_q[0]   <= io.in_a ^ b_eff;
            r_q[0]   <= io.in_a ^ b_eff;
            tag_q[0] <= io.in_tag;
            for (int s = 1; s < NB; s++) begin
                g_q[s]   <= bank_g[s-1];
                p_q[s]   <= bank_p[s-1];
                r_q[s]   <= r_q[s-1];
                tag_q[s] <= tag_q[s-1];
                v_q[s]   <= v_q[s-1];
            end
            sum0_q    <= sum0_d;
            sum1_q    <= sum1_d;
            cout0_q   <= cout0_d;
            cout1_q   <= cout1_d;
            tag_o_q   <= tag_q[NB-1];
            valid_o_q <= v_q[NB-1];
        end
    end

    assign io.out_valid = valid_o_q;
    assign io.out_sum0  = sum0_q;
    assign io.out_sum1  = sum1_q;
    assign io.out_cout0 = cout0_q;
    assign io.out_cout1 = cout1_q;
    assign io.out_tag   = tag_o_q;
endmodule

// File: tb/tb_ks_sum_inc_pipe.sv
// tb/tb_ks_sum_inc_pipe.sv - scoreboard bench for ks_sum_inc_pipe at 16/2 and 13/1
module tb_ks_sum_inc_pipe;
    localparam int W   = 16;
    localparam int RE  = 2;
    localparam int TW  = 4;
    localparam int LAT = 3;
    localparam int W2  = 13;
    localparam int RE2 = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ks_sum_inc_pipe_if #(.WIDTH(W),  .TAG_W(TW)) bus  ();
    ks_sum_inc_pipe_if #(.WIDTH(W2), .TAG_W(TW)) bus2 ();

    ks_sum_inc_pipe #(.WIDTH(W),  .REG_EVERY(RE),  .TAG_W(TW)) dut  (.clk(clk), .rst(rst), .io(bus));
    ks_sum_inc_pipe #(.WIDTH(W2), .REG_EVERY(RE2), .TAG_W(TW)) dut2 (.clk(clk), .rst(rst), .io(bus2));

    int n_checks = 0;
    int n_errors = 0;
    int n_out1   = 0;
    int n_out2   = 0;

    logic [63:0] q1[$];
    logic [63:0] q2[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic [3:0] tag);
        logic [32:0] mask, bp, r0, r1, s0, s1;
        mask = (33'd1 << w) - 33'd1;
        bp   = sub ? (~{1'b0, b}) & mask : {1'b0, b} & mask;
        r0   = ({1'b0, a} & mask) + bp;
        r1   = r0 + 33'd1;
        s0   = r0 & mask;
        s1   = r1 & mask;
        return {26'd0, tag, r1[w], r0[w], s1[15:0], s0[15:0]};
    endfunction

    function automatic logic [63:0] obs1();
        return {26'd0, bus.out_tag, bus.out_cout1, bus.out_cout0, bus.out_sum1, bus.out_sum0};
    endfunction

    function automatic logic [63:0] obs2();
        return {26'd0, bus2.out_tag, bus2.out_cout1, bus2.out_cout0, 3'd0, bus2.out_sum1, 3'd0, bus2.out_sum0};
    endfunction

    bit          hold1_v = 1'b0;
    logic [63:0] hold1;
    always @(negedge clk) begin
        if (rst) begin
            hold1_v = 1'b0;
        end else begin
            chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (hold1_v) chk("hold", obs1(), hold1);
            hold1_v = bus.out_valid && !bus.out_ready;
            hold1   = obs1();
            if (bus.out_valid && bus.out_ready) begin
                if (q1.size() == 0) chk("orphan", bus.out_valid, 1'b0);
                else begin
                    chk("result", obs1(), q1.pop_front());
                    n_out1++;
                end
            end
            if (bus.in_valid && bus.in_ready)
                q1.push_back(model(W, 32'(bus.in_a), 32'(bus.in_b), bus.in_sub, bus.in_tag));
        end
    end

    bit          hold2_v = 1'b0;
    logic [63:0] hold2;
    always @(negedge clk) begin
        if (rst) begin
            hold2_v = 1'b0;
        end else begin
            chk("in_ready_rule_w13", bus2.in_ready, !bus2.out_valid || bus2.out_ready);
            if (hold2_v) chk("hold_w13", obs2(), hold2);
            hold2_v = bus2.out_valid && !bus2.out_ready;
            hold2   = obs2();
            if (bus2.out_valid && bus2.out_ready) begin
                if (q2.size() == 0) chk("orphan_w13", bus2.out_valid, 1'b0);
                else begin
                    chk("result_w13", obs2(), q2.pop_front());
                    n_out2++;
                end
            end
            if (bus2.in_valid && bus2.in_ready)
                q2.push_back(model(W2, 32'(bus2.in_a), 32'(bus2.in_b), bus2.in_sub, bus2.in_tag));
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic [3:0] t);
        bit acc;
        int n;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_tag   = t;
        n   = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_check(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic [3:0] t,
                              input logic [15:0] s0, input logic [15:0] s1, input logic c0, input logic c1);
        int lat;
        send(a, b, sub, t);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, LAT);
        chk("sum0",  bus.out_sum0,  s0);
        chk("sum1",  bus.out_sum1,  s1);
        chk("cout0", bus.out_cout0, c0);
        chk("cout1", bus.out_cout1, c1);
        chk("tag",   bus.out_tag,   t);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.in_valid   = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sub = 1'b0; bus.in_tag = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_sub = 1'b0; bus2.in_tag = '0;
        bus2.out_ready = 1'b1;

        #2 rst = 1'b1;
        #2;
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data",  obs1(), 64'd0);
        chk("rst_valid_w13", bus2.out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;

        send_check(16'h1234, 16'h0FF0, 1'b0, 4'd5, 16'h2224, 16'h2225, 1'b0, 1'b0);
        send_check(16'hFFFF, 16'h0000, 1'b0, 4'd6, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        send_check(16'h8000, 16'h8000, 1'b0, 4'd7, 16'h0000, 16'h0001, 1'b1, 1'b1);
        send_check(16'h0005, 16'h0007, 1'b1, 4'd8, 16'hFFFD, 16'hFFFE, 1'b0, 1'b0);
        send_check(16'h0007, 16'h0007, 1'b1, 4'd9, 16'hFFFF, 16'h0000, 1'b0, 1'b1);

        // streaming with a three-cycle downstream stall
        @(posedge clk);
        #1;
        base = n_out1;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(16'($urandom), 16'($urandom), 1'(i % 2), 4'(i));
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    if (c == 4) bus.out_ready = 1'b0;
                    if (c == 6) chk("stall_in_ready", bus.in_ready, 1'b0);
                    if (c == 7) bus.out_ready = 1'b1;
                    @(posedge clk);
                    #1;
                end
            end
        join
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        chk("stream_count", n_out1 - base, 10);
        chk("stream_drain", q1.size(), 0);

        // reset with three beats in flight
        send(16'h1111, 16'h2222, 1'b0, 4'hA);
        send(16'h3333, 16'h4444, 1'b0, 4'hB);
        send(16'h5555, 16'h6666, 1'b1, 4'hC);
        rst = 1'b1;
        q1.delete();
        #1;
        chk("rst_mid_valid", bus.out_valid, 1'b0);
        chk("rst_mid_data",  obs1(), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst2", bus.in_ready, 1'b1);
        base = n_out1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("no_ghost_beats", n_out1 - base, 0);
        send_check(16'h00FF, 16'h0001, 1'b0, 4'd3, 16'h0100, 16'h0101, 1'b0, 1'b0);

        // randomised traffic on the 16-bit instance
        for (int i = 0; i < 10000; i++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_a      = 16'($urandom);
            bus.in_b      = 16'($urandom);
            bus.in_sub    = 1'($urandom);
            bus.in_tag    = 4'($urandom);
            bus.out_ready = ($urandom_range(3) != 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("rand_drain", q1.size(), 0);

        // randomised traffic on the 13-bit, one-level-per-stage instance
        for (int i = 0; i < 10000; i++) begin
            bus2.in_valid  = ($urandom_range(3) != 0);
            bus2.in_a      = 13'($urandom);
            bus2.in_b      = 13'($urandom);
            bus2.in_sub    = 1'($urandom);
            bus2.in_tag    = 4'($urandom);
            bus2.out_ready = ($urandom_range(3) != 0);
            @(posedge clk);
            #1;
        end
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        chk("rand_drain_w13", q2.size(), 0);
        chk("w13_saw_results", n_out2 > 1000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ks_sum_inc_pipe.md
Name: ks_sum_inc_pipe

Overview:
- Parametrised, pipelined Kogge-Stone compound adder.
- Each accepted operand pair produces two results at once: S0 = A + B' and S1 = A + B' + 1, where B' is B or ~B depending on mode.
- Successor to the single-bit combinational prefix cells. Sits in the datapath wherever an add, subtract or add-plus-one is needed at full clock rate.
- Valid/ready handshake on both sides; pipeline register depth is set at build time.

Parameters:
- WIDTH, 16, operand and result width in bits (>= 2).
- REG_EVERY, 2, number of Kogge-Stone prefix levels between pipeline registers (>= 1).
- TAG_W, 4, width of the sideband tag carried alongside each operation (>= 1).
- Derived, not overridable: L = ceil(log2(WIDTH)) prefix levels; LAT = 1 + ceil(L/REG_EVERY). WIDTH=16, REG_EVERY=2 gives L=4, LAT=3.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0: B' = B; 1: B' = ~B.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts a result.
- out_sum0  out  WIDTH  (A + B') mod 2^WIDTH.
- out_sum1  out  WIDTH  (A + B' + 1) mod 2^WIDTH; equals A - B when in_sub = 1.
- out_cout0  out  1  carry out of A + B'.
- out_cout1  out  1  carry out of A + B' + 1.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset (async, any cycle, including mid-operation):
  - All stage valid bits and all data/tag registers clear to 0.
  - Outputs read out_valid=0, out_sum0=0, out_sum1=0, out_cout0=0, out_cout1=0, out_tag=0.
  - In-flight operations are discarded and never appear.
  - On the first edge after rst deasserts, in_ready=1.
- Stage 1: registers bitwise g = A & B' and p = A ^ B', the raw p, and the tag.
- Prefix network:
  - Level k (k = 0..L-1) combines span 2^k: G = Gi | (Pi & Gj), P = Pi & Pj.
  - Positions with j < 0 pass through unchanged.
  - A register bank follows every REG_EVERY levels. The last bank also holds the final sums.
- Final sums, registered in stage LAT, with carry-in to bit 0 of S0 being 0:
  - S0[i] = p[i] ^ G[i-1:0].
  - S1[i] = p[i] ^ (G[i-1:0] | P[i-1:0]).
  - cout0 = G[W-1:0].
  - cout1 = G[W-1:0] | P[W-1:0].
  - The all-ones propagate term supplies the +1 ripple. No second adder is built.
- Latency: a beat accepted at edge n presents out_valid=1 with its results after edge n+LAT-1, i.e. LAT edges after acceptance, with no stall.
- Throughput: 1 beat per cycle.
- Handshake:
  - A beat transfers on an edge where valid & ready.
  - in_ready = !out_valid | out_ready; stall is global.
  - When in_ready=0, every stage register holds its value.
  - in_ready is combinational from out_ready and must not depend on in_valid.
  - Bubbles (in_valid=0 while in_ready=1) propagate as invalid stages and do not block.
- Hold rule: out_* must stay stable while out_valid=1 and out_ready=0.
- Ordering: results emerge in acceptance order; tags are never reordered or duplicated.
- Boundary conditions:
  - A = all ones, B = 0, add: S0 = all ones, S1 = 0, cout0=0, cout1=1.
  - A = B, sub: S1 = 0, cout1 = 1 (no borrow).
  - A < B, sub: cout1 = 0 (borrow).
- Simultaneous out_ready rise and new in_valid: the beat is accepted and the pipeline advances in the same edge.
- WIDTH not a power of two: the top level spans are truncated with no padding visible at the ports.

Test Plan (WIDTH=16, REG_EVERY=2, TAG_W=4, LAT=3):
- Basic add: A=0x1234, B=0x0FF0, sub=0, tag=5, out_ready=1 → 3 edges later out_valid=1, sum0=0x2224, sum1=0x2225, cout0=0, cout1=0, tag=5.
- Carry chain: A=0xFFFF, B=0x0000, add → sum0=0xFFFF, cout0=0, sum1=0x0000, cout1=1. Also A=0x8000, B=0x8000 → sum0=0x0000, cout0=1, sum1=0x0001, cout1=1.
- Subtract: A=0x0005, B=0x0007, sub=1 → sum1=0xFFFE, cout1=0. A=0x0007, B=0x0007 → sum1=0x0000, cout1=1.
- Streaming with backpressure:
  - Drive 10 back-to-back beats, tags 0..9, with out_ready low for cycles 4-6.
  - in_ready must drop with out_valid=1 & out_ready=0.
  - Outputs hold while stalled.
  - All 10 tags emerge in order, none lost or duplicated, each result matching a golden model.
- Reset mid-stream: 3 beats in flight, assert rst between edges → out_valid and all outputs 0 immediately. None of the 3 tags ever appear. After release, a new beat completes with latency 3.
- Randomised: 10k random A/B/sub/tag with random in_valid and out_ready → every result matches (A + B') and (A + B' + 1) including carries. Repeat with WIDTH=13, REG_EVERY=1 (LAT=5).
